// File: rtl/video_pkg.sv
// Shared definitions for the video processing paths: operation modes, luma
// coefficients and the colour-bar table.
package video_pkg;

  typedef enum logic [2:0] {
    MODE_PASS   = 3'd0,
    MODE_INVERT = 3'd1,
    MODE_GRAY   = 3'd2,
    MODE_RED    = 3'd3,
    MODE_GREEN  = 3'd4,
    MODE_BLUE   = 3'd5,
    MODE_BARS   = 3'd6,
    MODE_BLACK  = 3'd7
  } video_mode_e;

  localparam int unsigned LUMA_R     = 77;
  localparam int unsigned LUMA_G     = 150;
  localparam int unsigned LUMA_B     = 29;
  localparam int unsigned LUMA_SHIFT = 8;

  localparam int unsigned NUM_BARS  = 8;
  localparam int unsigned BAR_IDX_W = 3;

  // {red, green, blue} full-scale enables per bar, left to right
  function automatic logic [2:0] bar_mask(input logic [BAR_IDX_W-1:0] idx);
    case (idx)
      3'd0:    return 3'b111;  // white
      3'd1:    return 3'b110;  // yellow
      3'd2:    return 3'b011;  // cyan
      3'd3:    return 3'b010;  // green
      3'd4:    return 3'b101;  // magenta
      3'd5:    return 3'b100;  // red
      3'd6:    return 3'b001;  // blue
      default: return 3'b000;  // black
    endcase
  endfunction

endpackage

// File: rtl/video_timing_meas.sv
// Sync edge detection and active-resolution measurement; produces the
// frame-start pulse used by the pixel paths.
module video_timing_meas #(
  parameter int unsigned CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dv,
  input  logic             vs,
  output logic             frame_start_c,
  output logic             dv_rise_c,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_active,
  output logic             meas_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             dv_d, vs_d, dv_fall;
  logic [CNT_W-1:0] x_cnt, y_cnt, line_len;

  assign frame_start_c = vs & ~vs_d;
  assign dv_rise_c     = dv & ~dv_d;
  assign dv_fall       = ~dv & dv_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dv_d       <= 1'b0;
      vs_d       <= 1'b0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      line_len   <= '0;
      h_active   <= '0;
      v_active   <= '0;
      meas_valid <= 1'b0;
    end else begin
      dv_d <= dv;
      vs_d <= vs;
      if (dv_rise_c)
        x_cnt <= CNT_ONE;
      else if (dv && x_cnt != CNT_MAX)
        x_cnt <= x_cnt + CNT_ONE;
      if (dv_fall)
        line_len <= x_cnt;
      // Frame start wins over a coincident line start, which becomes line 1
      if (frame_start_c) begin
        h_active   <= line_len;
        v_active   <= y_cnt;
        meas_valid <= (line_len == h_active) && (y_cnt == v_active) &&
                      (line_len != '0) && (y_cnt != '0);
        y_cnt      <= dv_rise_c ? CNT_ONE : '0;
      end else if (dv_rise_c && y_cnt != CNT_MAX) begin
        y_cnt <= y_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/video_proc_path.sv
// Frame-synchronous pixel operation stage between hdmi_rx and hdmi_tx, with
// syncs delayed to match the colour pipeline exactly.
module video_proc_path #(
  parameter int unsigned CW    = 8,
  parameter int unsigned LAT   = 2,
  parameter int unsigned CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       mode,
  input  logic [CW-1:0]    rx_red,
  input  logic [CW-1:0]    rx_green,
  input  logic [CW-1:0]    rx_blue,
  input  logic             rx_dv,
  input  logic             rx_hs,
  input  logic             rx_vs,
  output logic [CW-1:0]    tx_red,
  output logic [CW-1:0]    tx_green,
  output logic [CW-1:0]    tx_blue,
  output logic             tx_dv,
  output logic             tx_hs,
  output logic             tx_vs,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_active,
  output logic             meas_valid,
  output logic [2:0]       mode_active
);
  import video_pkg::*;

  localparam int unsigned PW     = CW + LUMA_SHIFT;
  localparam int unsigned PIX_W  = 3 * CW;
  localparam int          CDEPTH = int'(LAT) - 1;
  localparam int          SDEPTH = int'(LAT);
  localparam logic [CW-1:0]    CMAX    = '1;
  localparam logic [CW-1:0]    CMID    = {1'b1, {(CW-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [BAR_IDX_W-1:0] LAST_BAR = BAR_IDX_W'(NUM_BARS - 1);

  logic frame_start, dv_rise;

  video_timing_meas #(.CNT_W(CNT_W)) u_meas (
    .clk           (clk),
    .rst_n         (rst_n),
    .dv            (rx_dv),
    .vs            (rx_vs),
    .frame_start_c (frame_start),
    .dv_rise_c     (dv_rise),
    .h_active      (h_active),
    .v_active      (v_active),
    .meas_valid    (meas_valid)
  );

  // The frame-start pixel already uses the newly sampled mode
  logic        synced, synced_eff;
  video_mode_e mode_eff;
  assign mode_eff   = video_mode_e'(frame_start ? mode : mode_active);
  assign synced_eff = synced | frame_start;

  logic [CNT_W-1:0]     bar_w, bar_px, cur_px;
  logic [BAR_IDX_W-1:0] bar_idx, cur_idx;
  assign bar_w   = h_active >> BAR_IDX_W;
  assign cur_px  = dv_rise ? '0 : bar_px;
  assign cur_idx = dv_rise ? '0 : bar_idx;

  logic [CW-1:0] op_r, op_g, op_b;
  logic          op_gray;
  logic [2:0]    bar_m;

  // First pipeline stage: per-mode pixel operation, blanked outside active video
  always_comb begin
    op_r    = '0;
    op_g    = '0;
    op_b    = '0;
    op_gray = 1'b0;
    bar_m   = bar_mask(cur_idx);
    case (mode_eff)
      MODE_PASS:   begin op_r = rx_red; op_g = rx_green; op_b = rx_blue; end
      MODE_INVERT: begin
        op_r = CMAX - rx_red;
        op_g = CMAX - rx_green;
        op_b = CMAX - rx_blue;
      end
      MODE_GRAY:   op_gray = 1'b1;
      MODE_RED:    op_r = rx_red;
      MODE_GREEN:  op_g = rx_green;
      MODE_BLUE:   op_b = rx_blue;
      MODE_BARS: begin
        if (!meas_valid || bar_w == '0) begin
          op_r = CMID; op_g = CMID; op_b = CMID;
        end else begin
          op_r = bar_m[2] ? CMAX : '0;
          op_g = bar_m[1] ? CMAX : '0;
          op_b = bar_m[0] ? CMAX : '0;
        end
      end
      default: ;
    endcase
    if (!(rx_dv && synced_eff)) begin
      op_r    = '0;
      op_g    = '0;
      op_b    = '0;
      op_gray = 1'b0;
    end
  end

  logic [PW-1:0]    prod_r, prod_g, prod_b, luma_sum;
  logic [CW-1:0]    luma;
  logic             s1_gray;
  logic [PIX_W-1:0] s1_pix;
  logic [PIX_W-1:0] col_dly [CDEPTH];
  logic [2:0]       sync_dly [SDEPTH];

  assign luma_sum = prod_r + prod_g + prod_b;
  assign luma     = luma_sum[PW-1 -: CW];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_active <= '0;
      synced      <= 1'b0;
      bar_px      <= '0;
      bar_idx     <= '0;
      prod_r      <= '0;
      prod_g      <= '0;
      prod_b      <= '0;
      s1_gray     <= 1'b0;
      s1_pix      <= '0;
      for (int i = 0; i < CDEPTH; i++) col_dly[i] <= '0;
      for (int i = 0; i < SDEPTH; i++) sync_dly[i] <= '0;
    end else begin
      if (frame_start) begin
        mode_active <= mode;
        synced      <= 1'b1;
      end
      // Bar position: restarts every line, index saturates on the last bar
      if (rx_dv) begin
        if (cur_px == bar_w - CNT_ONE) begin
          bar_px  <= '0;
          bar_idx <= (cur_idx == LAST_BAR) ? cur_idx : cur_idx + BAR_IDX_W'(1);
        end else begin
          bar_px  <= cur_px + CNT_ONE;
          bar_idx <= cur_idx;
        end
      end
      prod_r  <= PW'(rx_red)   * PW'(LUMA_R);
      prod_g  <= PW'(rx_green) * PW'(LUMA_G);
      prod_b  <= PW'(rx_blue)  * PW'(LUMA_B);
      s1_gray <= op_gray;
      s1_pix  <= {op_r, op_g, op_b};
      col_dly[0] <= s1_gray ? {luma, luma, luma} : s1_pix;
      for (int i = 1; i < CDEPTH; i++) col_dly[i] <= col_dly[i-1];
      sync_dly[0] <= {rx_dv, rx_hs, rx_vs};
      for (int i = 1; i < SDEPTH; i++) sync_dly[i] <= sync_dly[i-1];
    end
  end

  assign {tx_red, tx_green, tx_blue} = col_dly[CDEPTH-1];
  assign {tx_dv, tx_hs, tx_vs}       = sync_dly[SDEPTH-1];

endmodule

// File: tb/tb_video_proc_path.sv
// Bench for video_proc_path: frame-level reference model checked every cycle,
// plus directed frames with hand-computed pixel and measurement values.
module tb_video_proc_path;

  localparam int unsigned CW    = 8;
  localparam int unsigned LAT   = 2;
  localparam int unsigned CNT_W = 12;
  localparam int MAXV    = (1 << CW) - 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int BAR_R [8] = '{1, 1, 0, 0, 1, 1, 0, 0};
  localparam int BAR_G [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
  localparam int BAR_B [8] = '{1, 0, 1, 0, 1, 0, 1, 0};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [2:0]       mode = 3'd0;
  logic [CW-1:0]    rx_red = '0, rx_green = '0, rx_blue = '0;
  logic             rx_dv = 1'b0, rx_hs = 1'b0, rx_vs = 1'b0;
  logic [CW-1:0]    tx_red, tx_green, tx_blue;
  logic             tx_dv, tx_hs, tx_vs;
  logic [CNT_W-1:0] h_active, v_active;
  logic             meas_valid;
  logic [2:0]       mode_active;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  video_proc_path #(.CW(CW), .LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode        (mode),
    .rx_red      (rx_red),
    .rx_green    (rx_green),
    .rx_blue     (rx_blue),
    .rx_dv       (rx_dv),
    .rx_hs       (rx_hs),
    .rx_vs       (rx_vs),
    .tx_red      (tx_red),
    .tx_green    (tx_green),
    .tx_blue     (tx_blue),
    .tx_dv       (tx_dv),
    .tx_hs       (tx_hs),
    .tx_vs       (tx_vs),
    .h_active    (h_active),
    .v_active    (v_active),
    .meas_valid  (meas_valid),
    .mode_active (mode_active)
  );

  typedef struct {
    int r, g, b;
    bit dv, hs, vs;
  } pix_t;

  pix_t expq[$];

  // Model state: what the frame/line rules say has been seen so far
  int m_h, m_v, m_xcnt, m_last, m_ycnt, m_pos, m_mode;
  bit m_mv, m_sync, m_pdv, m_pvs;

  function automatic pix_t zero_pix();
    pix_t p;
    p.r = 0; p.g = 0; p.b = 0; p.dv = 0; p.hs = 0; p.vs = 0;
    return p;
  endfunction

  function automatic pix_t model_pix(int r, int g, int b, bit dv, bit hs, bit vs,
                                     int md, bit sy, int pos);
    pix_t p;
    int y, w, k;
    p = zero_pix();
    p.dv = dv; p.hs = hs; p.vs = vs;
    if (dv && sy) begin
      case (md)
        0: begin p.r = r; p.g = g; p.b = b; end
        1: begin p.r = MAXV - r; p.g = MAXV - g; p.b = MAXV - b; end
        2: begin
          y = (77 * r + 150 * g + 29 * b) / 256;
          p.r = y; p.g = y; p.b = y;
        end
        3: p.r = r;
        4: p.g = g;
        5: p.b = b;
        6: begin
          w = m_h / 8;
          if (!m_mv || w == 0) begin
            p.r = 1 << (CW - 1); p.g = 1 << (CW - 1); p.b = 1 << (CW - 1);
          end else begin
            k = pos / w;
            if (k > 7) k = 7;
            p.r = BAR_R[k] * MAXV; p.g = BAR_G[k] * MAXV; p.b = BAR_B[k] * MAXV;
          end
        end
        default: ;
      endcase
    end
    return p;
  endfunction

  // Per-cycle compare against the model
  always @(posedge clk) begin
    pix_t e;
    bit   fs, rise, fall, sy;
    int   md, pos, nh, nv;
    #1;
    cyc++;
    if (!rst_n) begin
      n_cmp++;
      if ({tx_red, tx_green, tx_blue, tx_dv, tx_hs, tx_vs, h_active, v_active,
           meas_valid, mode_active} !== '0) begin
        n_bad++;
        $display("FAIL reset_state cyc %0d: rgb=%h/%h/%h sync=%b%b%b h=%0d v=%0d mv=%b mode=%0d, required all zero",
                 cyc, tx_red, tx_green, tx_blue, tx_dv, tx_hs, tx_vs, h_active, v_active,
                 meas_valid, mode_active);
      end
      m_h = 0; m_v = 0; m_xcnt = 0; m_last = 0; m_ycnt = 0; m_pos = 0; m_mode = 0;
      m_mv = 0; m_sync = 0; m_pdv = 0; m_pvs = 0;
      expq.delete();
      for (int i = 0; i < int'(LAT) - 1; i++) expq.push_back(zero_pix());
    end else begin
      fs   = rx_vs && !m_pvs;
      rise = rx_dv && !m_pdv;
      fall = !rx_dv && m_pdv;
      md   = fs ? int'(mode) : m_mode;
      sy   = m_sync || fs;
      pos  = rise ? 0 : m_pos;
      e = model_pix(int'(rx_red), int'(rx_green), int'(rx_blue), rx_dv, rx_hs, rx_vs,
                    md, sy, pos);
      if (rx_dv) m_pos = pos + 1;
      if (fs) begin
        nh = m_last; nv = m_ycnt;
        m_mv = (nh == m_h) && (nv == m_v) && (nh != 0) && (nv != 0);
        m_h = nh; m_v = nv;
        m_ycnt = rise ? 1 : 0;
        m_mode = int'(mode);
        m_sync = 1;
      end else if (rise && m_ycnt < CNT_MAX) begin
        m_ycnt++;
      end
      if (fall) m_last = m_xcnt;
      if (rise) m_xcnt = 1;
      else if (rx_dv && m_xcnt < CNT_MAX) m_xcnt++;
      m_pdv = rx_dv; m_pvs = rx_vs;
      expq.push_back(e);
      e = expq.pop_front();
      n_cmp++;
      if (int'(tx_red) !== e.r || int'(tx_green) !== e.g || int'(tx_blue) !== e.b ||
          tx_dv !== e.dv || tx_hs !== e.hs || tx_vs !== e.vs) begin
        n_bad++;
        $display("FAIL tx_pixel cyc %0d: got rgb=%h/%h/%h sync=%b%b%b, required rgb=%h/%h/%h sync=%b%b%b",
                 cyc, tx_red, tx_green, tx_blue, tx_dv, tx_hs, tx_vs,
                 e.r, e.g, e.b, e.dv, e.hs, e.vs);
      end
      n_cmp++;
      if (int'(h_active) !== m_h || int'(v_active) !== m_v || meas_valid !== m_mv ||
          int'(mode_active) !== m_mode) begin
        n_bad++;
        $display("FAIL status cyc %0d: got h=%0d v=%0d mv=%b mode=%0d, required h=%0d v=%0d mv=%b mode=%0d",
                 cyc, h_active, v_active, meas_valid, mode_active, m_h, m_v, m_mv, m_mode);
      end
    end
  end

  logic [CW-1:0] cap_r [0:63];
  logic [CW-1:0] cap_g [0:63];
  logic [CW-1:0] cap_b [0:63];
  logic          cap_dv [0:63];
  logic          pre_dv;

  task automatic step(bit dv, bit hs, bit vs, logic [CW-1:0] r, logic [CW-1:0] g,
                      logic [CW-1:0] b);
    rx_dv = dv; rx_hs = hs; rx_vs = vs;
    rx_red = r; rx_green = g; rx_blue = b;
    @(negedge clk);
  endtask

  task automatic vsync();
    step(0, 0, 1, '0, '0, '0);
    step(0, 0, 1, '0, '0, '0);
    step(0, 0, 0, '0, '0, '0);
    step(0, 0, 0, '0, '0, '0);
  endtask

  // One line; cap_* index i holds the tx output belonging to input pixel i
  task automatic line(int len, logic [CW-1:0] r, logic [CW-1:0] g, logic [CW-1:0] b,
                      bit vs_start);
    step(0, 1, 0, '0, '0, '0);
    step(0, 1, 0, '0, '0, '0);
    step(0, 0, 0, '0, '0, '0);
    for (int q = 0; q <= len + int'(LAT); q++) begin
      if (q == int'(LAT) - 1) pre_dv = tx_dv;
      if (q >= int'(LAT)) begin
        cap_r[q - int'(LAT)]  = tx_red;
        cap_g[q - int'(LAT)]  = tx_green;
        cap_b[q - int'(LAT)]  = tx_blue;
        cap_dv[q - int'(LAT)] = tx_dv;
      end
      if (q < len) step(1, 0, vs_start && q < 2, r, g, b);
      else         step(0, 0, 0, '0, '0, '0);
    end
  endtask

  task automatic lines(int n, logic [CW-1:0] r, logic [CW-1:0] g, logic [CW-1:0] b);
    for (int i = 0; i < n; i++) line(16, r, g, b, 0);
  endtask

  task automatic check_val(string name, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic check_rgb(string name, int i, logic [3*CW-1:0] exp);
    logic [3*CW-1:0] got;
    got = {cap_r[i], cap_g[i], cap_b[i]};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: pixel %0d got %h, required %h", name, i, got, exp);
    end
  endtask

  initial begin
    step(0, 0, 0, '0, '0, '0);
    step(0, 0, 0, '0, '0, '0);
    step(0, 0, 0, '0, '0, '0);
    rst_n = 1'b1;
    // No frame start yet: syncs pass through, colour stays black
    line(16, 8'h12, 8'h80, 8'hFF, 0);
    check_val("unsynced_colour", int'({cap_r[5], cap_g[5], cap_b[5]}), 0);
    check_val("unsynced_dv", int'(cap_dv[5]), 1);

    // Reset in the middle of an active line
    step(0, 1, 0, '0, '0, '0);
    step(0, 0, 0, '0, '0, '0);
    for (int q = 0; q < 12; q++) begin
      rst_n = !(q >= 4 && q < 7);
      step(1, 0, 0, 8'h12, 8'h80, 8'hFF);
    end
    rst_n = 1'b1;
    step(0, 0, 0, '0, '0, '0);
    line(16, 8'h12, 8'h80, 8'hFF, 0);

    // vs #1: two partial-frame lines were seen since reset
    vsync();
    check_val("vs1_h", int'(h_active), 16);
    check_val("vs1_v", int'(v_active), 2);
    check_val("vs1_mv", int'(meas_valid), 0);
    line(16, 8'h12, 8'h80, 8'hFF, 0);
    check_rgb("pass", 8, 24'h1280FF);
    lines(3, 8'h12, 8'h80, 8'hFF);

    // vs #2: bars requested before the measurement is stable
    mode = 3'd6;
    vsync();
    check_val("vs2_mv", int'(meas_valid), 0);
    check_val("vs2_v", int'(v_active), 4);
    check_val("vs2_mode", int'(mode_active), 6);
    line(16, 8'h12, 8'h80, 8'hFF, 0);
    check_rgb("bars_flat", 3, 24'h808080);
    lines(3, 8'h12, 8'h80, 8'hFF);

    // vs #3: measurement stable; invert requested mid-frame
    mode = 3'd0;
    vsync();
    check_val("vs3_mv", int'(meas_valid), 1);
    check_val("vs3_h", int'(h_active), 16);
    line(16, 8'h12, 8'h80, 8'hFF, 0);
    mode = 3'd1;
    line(16, 8'h12, 8'h80, 8'hFF, 0);
    check_val("midframe_mode", int'(mode_active), 0);
    check_rgb("midframe_pass", 8, 24'h1280FF);
    lines(2, 8'h12, 8'h80, 8'hFF);

    vsync();
    check_val("vs4_mode", int'(mode_active), 1);
    line(16, 8'h12, 8'h80, 8'hFF, 0);
    check_rgb("invert", 8, 24'hED7F00);
    lines(3, 8'h12, 8'h80, 8'hFF);

    // Grayscale: 77*255>>8 = 76, 29*255>>8 = 28, (77*18+150*128+29*255)>>8 = 109
    mode = 3'd2;
    vsync();
    line(16, 8'hFF, 8'hFF, 8'hFF, 0);
    check_rgb("gray_white", 8, 24'hFFFFFF);
    check_val("gray_lat_before", int'(pre_dv), 0);
    check_val("gray_lat_first", int'(cap_dv[0]), 1);
    check_val("gray_lat_after", int'(cap_dv[16]), 0);
    line(16, 8'hFF, 8'h00, 8'h00, 0);
    check_rgb("gray_red", 0, 24'h4C4C4C);
    line(16, 8'h00, 8'h00, 8'hFF, 0);
    check_rgb("gray_blue", 15, 24'h1C1C1C);
    line(16, 8'h12, 8'h80, 8'hFF, 0);
    check_rgb("gray_mix", 8, 24'h6D6D6D);

    // Colour bars, 2 pixels wide for a 16-pixel line
    mode = 3'd6;
    vsync();
    line(16, 8'h12, 8'h80, 8'hFF, 0);
    check_rgb("bar0_a", 0, 24'hFFFFFF);
    check_rgb("bar0", 1, 24'hFFFFFF);
    check_rgb("bar1", 3, 24'hFFFF00);
    check_rgb("bar2", 5, 24'h00FFFF);
    check_rgb("bar3", 7, 24'h00FF00);
    check_rgb("bar4", 9, 24'hFF00FF);
    check_rgb("bar5", 11, 24'hFF0000);
    check_rgb("bar6", 13, 24'h0000FF);
    check_rgb("bar7", 15, 24'h000000);
    line(16, 8'h12, 8'h80, 8'hFF, 0);
    mode = 3'd7;
    line(16, 8'h12, 8'h80, 8'hFF, 0);
    check_val("bars_mode_held", int'(mode_active), 6);
    line(16, 8'h12, 8'h80, 8'hFF, 0);

    // vs rising together with the first dv of a line
    line(16, 8'h12, 8'h80, 8'hFF, 1);
    check_val("coincide_mode", int'(mode_active), 7);
    check_rgb("black", 0, 24'h000000);
    lines(3, 8'h12, 8'h80, 8'hFF);
    vsync();
    check_val("coincide_v", int'(v_active), 4);
    check_val("coincide_h", int'(h_active), 16);
    check_val("coincide_mv", int'(meas_valid), 1);
    line(16, 8'h12, 8'h80, 8'hFF, 0);
    step(0, 0, 0, '0, '0, '0);
    step(0, 0, 0, '0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
